serial_byte_rx: RTL and testbench

Serial-to-parallel receive stage placed directly downstream of the 8-bit shift register. It takes the serial bit stream from the register's MSB tap (`Q[7]`), frames it as start / 8 data / [parity] / stop, and reassembles each byte. Good bytes are queued in a small FIFO and presented on a valid/ready byte interface to the next consumer. Framing faults and FIFO overflow are reported on status outputs.

---
 rtl/serial_byte_rx.sv | 102 ++++++++++
 tb/tb_serial_byte_rx.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/serial_byte_rx.sv
// serial_byte_rx: frames a serial bit stream (start / 8 data MSB-first / [even parity] / stop) into bytes and queues them in a FIFO.
// Ports: clk, rst (async, active-high); bit_en qualifies s_bit; dout/dout_valid/dout_ready form the byte output;
// frame_err pulses on a rejected frame; overflow is sticky; level is FIFO occupancy.
// Optional parity stage enabled by defining SERIAL_RX_PARITY_EN.
module serial_byte_rx #(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       bit_en,
  input  logic                       s_bit,
  output logic [7:0]                 dout,
  output logic                       dout_valid,
  input  logic                       dout_ready,
  output logic                       frame_err,
  output logic                       overflow,
  output logic [$clog2(DEPTH):0]     level
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
`ifdef SERIAL_RX_PARITY_EN
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
  logic par_err;
`else
  typedef enum logic [1:0] {IDLE, DATA, STOP} state_t;
`endif
  state_t state, state_n;
  logic [7:0] sh;
  logic [2:0] cnt;
  logic push, reject, pop, accept;
  logic [7:0] mem [DEPTH];
  logic [AW-1:0] rd, wr;
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    push = 1'b0;
    reject = 1'b0;
    if (bit_en)
      case (state)
        IDLE: state_n = s_bit ? IDLE : DATA;
`ifdef SERIAL_RX_PARITY_EN
        DATA: state_n = (cnt == 3'd7) ? PARITY : DATA;
        PARITY: state_n = STOP;
        STOP: begin
          push = s_bit & ~par_err;
          reject = ~push;
          state_n = IDLE;
        end
`else
        DATA: state_n = (cnt == 3'd7) ? STOP : DATA;
        STOP: begin
          push = s_bit;
          reject = ~s_bit;
          state_n = IDLE;
        end
`endif
        default: state_n = IDLE;
      endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sh <= '0;
      cnt <= '0;
      frame_err <= 1'b0;
`ifdef SERIAL_RX_PARITY_EN
      par_err <= 1'b0;
`endif
    end else begin
      frame_err <= reject;
      if (bit_en && state == IDLE && !s_bit) cnt <= '0;
      if (bit_en && state == DATA) begin
        sh <= {sh[6:0], s_bit};
        cnt <= cnt + 3'd1;
      end
`ifdef SERIAL_RX_PARITY_EN
      if (bit_en && state == PARITY) par_err <= ^{sh, s_bit};
`endif
    end
  assign dout_valid = level != '0;
  assign dout = mem[rd];
  assign pop = dout_valid && dout_ready;
  // a pop on the same edge frees the slot, so a full FIFO still accepts
  assign accept = push && (level != FULL || pop);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      rd <= '0;
      wr <= '0;
      level <= '0;
      overflow <= 1'b0;
    end else begin
      if (accept) begin
        mem[wr] <= sh;
        wr <= wr + 1'b1;
      end
      if (pop) rd <= rd + 1'b1;
      level <= level + (AW+1)'(accept) - (AW+1)'(pop);
      if (push && !accept) overflow <= 1'b1;
    end
endmodule

// File: tb/tb_serial_byte_rx.sv
// tb_serial_byte_rx: scoreboard bench for serial_byte_rx.
module tb_serial_byte_rx;
  localparam int DEPTH = 4;
  logic clk = 1'b0, rst = 1'b1, bit_en = 1'b0, s_bit = 1'b1, dout_ready = 1'b0;
  logic [7:0] dout;
  logic dout_valid, frame_err, overflow;
  logic [$clog2(DEPTH):0] level;
  logic [7:0] q[$];
  logic [7:0] exp_b;
  int n_cmp = 0, n_bad = 0;

  serial_byte_rx #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .bit_en(bit_en), .s_bit(s_bit), .dout(dout),
    .dout_valid(dout_valid), .dout_ready(dout_ready), .frame_err(frame_err),
    .overflow(overflow), .level(level)
  );

  always #5 clk = ~clk;

  // drives a frame on falling edges; returns at the falling edge after the stop sample
  task automatic send_frame(input logic [7:0] d, input logic stop, input logic par_flip, input logic pop_at_stop);
    @(negedge clk) begin bit_en = 1'b1; s_bit = 1'b0; end
    for (int i = 7; i >= 0; i--) @(negedge clk) s_bit = d[i];
`ifdef SERIAL_RX_PARITY_EN
    @(negedge clk) s_bit = (^d) ^ par_flip;
`endif
    @(negedge clk) begin s_bit = stop; dout_ready = pop_at_stop; end
    @(negedge clk) begin bit_en = 1'b0; s_bit = 1'b1; dout_ready = 1'b0; end
  endtask

  // scoreboard consumer: compares the head against the oldest expected byte and pops it
  task automatic drain_one(input string name);
    n_cmp++;
    if (q.size() == 0 || dout_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL %s valid: got %b required 1 (queued %0d)", name, dout_valid, q.size());
    end else begin
      exp_b = q.pop_front();
      n_cmp++;
      if (dout !== exp_b) begin n_bad++; $display("FAIL %s data: got %h required %h", name, dout, exp_b); end
    end
    dout_ready = 1'b1;
    @(negedge clk) dout_ready = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    q.delete();
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (level !== 0) begin n_bad++; $display("FAIL reset_level: got %0d required 0", level); end
    n_cmp++; if (dout_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b required 0", dout_valid); end
    n_cmp++; if (dout !== 8'h00) begin n_bad++; $display("FAIL reset_dout: got %h required 00", dout); end
    n_cmp++; if (overflow !== 1'b0 || frame_err !== 1'b0) begin n_bad++; $display("FAIL reset_flags: got ovf=%b ferr=%b required 0 0", overflow, frame_err); end
    @(negedge clk) begin bit_en = 1'b1; s_bit = 1'b0; end
    @(negedge clk) s_bit = 1'b1;
    @(negedge clk) s_bit = 1'b0;
    @(negedge clk) s_bit = 1'b1;
    #3 rst = 1'b1;
    @(negedge clk) begin rst = 1'b0; bit_en = 1'b0; end
    n_cmp++; if (level !== 0 || dout_valid !== 1'b0 || overflow !== 1'b0) begin n_bad++; $display("FAIL midframe_reset: got level=%0d valid=%b ovf=%b required 0 0 0", level, dout_valid, overflow); end
    send_frame(8'h3C, 1'b1, 1'b0, 1'b0); q.push_back(8'h3C);
    drain_one("reset_next_frame");
  endtask

  task automatic test_single();
    n_cmp++; if (dout_valid !== 1'b0) begin n_bad++; $display("FAIL single_pre_valid: got %b required 0", dout_valid); end
    send_frame(8'hA5, 1'b1, 1'b0, 1'b0); q.push_back(8'hA5);
    n_cmp++; if (level !== 1) begin n_bad++; $display("FAIL single_level: got %0d required 1", level); end
    drain_one("single_data");
    n_cmp++; if (level !== 0 || dout_valid !== 1'b0) begin n_bad++; $display("FAIL single_after_pop: got level=%0d valid=%b required 0 0", level, dout_valid); end
  endtask

  task automatic test_frame_err();
    n_cmp++; if (frame_err !== 1'b0) begin n_bad++; $display("FAIL ferr_idle: got %b required 0", frame_err); end
    send_frame(8'hFF, 1'b0, 1'b0, 1'b0);
    n_cmp++; if (frame_err !== 1'b1) begin n_bad++; $display("FAIL ferr_pulse: got %b required 1", frame_err); end
    n_cmp++; if (level !== 0) begin n_bad++; $display("FAIL ferr_level: got %0d required 0", level); end
    @(negedge clk);
    n_cmp++; if (frame_err !== 1'b0) begin n_bad++; $display("FAIL ferr_width: got %b required 0", frame_err); end
    send_frame(8'h01, 1'b1, 1'b0, 1'b0); q.push_back(8'h01);
    n_cmp++; if (frame_err !== 1'b0) begin n_bad++; $display("FAIL ferr_good_frame: got %b required 0", frame_err); end
    drain_one("ferr_recover");
  endtask

  task automatic test_overflow();
    for (int i = 1; i <= 5; i++) begin
      send_frame(8'(i * 8'h11), 1'b1, 1'b0, 1'b0);
      if (q.size() < DEPTH) q.push_back(8'(i * 8'h11));
    end
    n_cmp++; if (level !== DEPTH) begin n_bad++; $display("FAIL ovf_level: got %0d required %0d", level, DEPTH); end
    n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_flag: got %b required 1", overflow); end
    for (int i = 0; i < DEPTH; i++) drain_one("ovf_order");
    n_cmp++; if (dout_valid !== 1'b0 || overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_after_drain: got valid=%b ovf=%b required 0 1", dout_valid, overflow); end
  endtask

  task automatic test_full_pushpop();
    do_reset();
    n_cmp++; if (dout !== 8'h00 || overflow !== 1'b0) begin n_bad++; $display("FAIL full_reset: got dout=%h ovf=%b required 00 0", dout, overflow); end
    for (int i = 1; i <= 4; i++) begin
      send_frame(8'(i * 8'h11), 1'b1, 1'b0, 1'b0);
      q.push_back(8'(i * 8'h11));
    end
    n_cmp++; if (dout !== 8'h11 || level !== DEPTH) begin n_bad++; $display("FAIL full_head: got dout=%h level=%0d required 11 %0d", dout, level, DEPTH); end
    send_frame(8'h66, 1'b1, 1'b0, 1'b1);
    void'(q.pop_front());
    q.push_back(8'h66);
    n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL full_ovf: got %b required 0", overflow); end
    n_cmp++; if (level !== DEPTH) begin n_bad++; $display("FAIL full_level: got %0d required %0d", level, DEPTH); end
    for (int i = 0; i < DEPTH; i++) drain_one("full_order");
    n_cmp++; if (level !== 0) begin n_bad++; $display("FAIL full_drained: got %0d required 0", level); end
  endtask

`ifdef SERIAL_RX_PARITY_EN
  task automatic test_parity();
    send_frame(8'hA5, 1'b1, 1'b0, 1'b0); q.push_back(8'hA5);
    n_cmp++; if (frame_err !== 1'b0) begin n_bad++; $display("FAIL par_good_ferr: got %b required 0", frame_err); end
    drain_one("par_good");
    send_frame(8'hA5, 1'b1, 1'b1, 1'b0);
    n_cmp++; if (frame_err !== 1'b1) begin n_bad++; $display("FAIL par_bad_ferr: got %b required 1", frame_err); end
    n_cmp++; if (level !== 0) begin n_bad++; $display("FAIL par_bad_level: got %0d required 0", level); end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_frame_err();
    test_overflow();
    test_full_pushpop();
`ifdef SERIAL_RX_PARITY_EN
    test_parity();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
